// File: rtl/fifo_buf_arbiter_pkg.sv
// Shared widths, requester codes and CPU command FSM states
// for the packet buffer arbiter.
package fifo_buf_arbiter_pkg;

  localparam int MEM_WIDTH    = 72;
  localparam int ADDR_WIDTH   = 10;
  localparam int CPU_MAX_WAIT = 8;
  localparam int WAIT_W       = $clog2(CPU_MAX_WAIT + 1);
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ING  = 2'd1,
    REQ_EGR  = 2'd2,
    REQ_CPU  = 2'd3
  } req_e;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_PEND = 2'd1;
  localparam logic [1:0] C_RDAT = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

endpackage

// File: rtl/fifo_buf_arbiter_if.sv
// Requester, CPU and RAM signals of the buffer arbiter.
// slave = arbiter side, master = environment side.
interface fifo_buf_arbiter_if;
  import fifo_buf_arbiter_pkg::*;

  logic                  ing_req;
  logic [ADDR_WIDTH-1:0] ing_addr;
  logic [MEM_WIDTH-1:0]  ing_wdata;
  logic                  ing_gnt;

  logic                  egr_req;
  logic [ADDR_WIDTH-1:0] egr_addr;
  logic                  egr_gnt;
  logic                  egr_rvalid;
  logic [MEM_WIDTH-1:0]  egr_rdata;

  logic                  cpu_cmd_stb;
  logic                  cpu_wen;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [MEM_WIDTH-1:0]  cpu_wdata;
  logic                  cpu_lock;
  logic                  cpu_busy;
  logic                  cpu_done;
  logic [MEM_WIDTH-1:0]  cpu_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_wdata;
  logic [MEM_WIDTH-1:0]  mem_rdata;

  logic [CNT_W-1:0]      conflict_cnt;

  modport slave (
    input  ing_req, ing_addr, ing_wdata,
    output ing_gnt,
    input  egr_req, egr_addr,
    output egr_gnt, egr_rvalid, egr_rdata,
    input  cpu_cmd_stb, cpu_wen, cpu_addr,
    input  cpu_wdata, cpu_lock,
    output cpu_busy, cpu_done, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output conflict_cnt
  );

  modport master (
    output ing_req, ing_addr, ing_wdata,
    input  ing_gnt,
    output egr_req, egr_addr,
    input  egr_gnt, egr_rvalid, egr_rdata,
    output cpu_cmd_stb, cpu_wen, cpu_addr,
    output cpu_wdata, cpu_lock,
    input  cpu_busy, cpu_done, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  conflict_cnt
  );

endinterface

// File: rtl/fifo_buf_arbiter_cpu_cmd_fsm.sv
// CPU command latch, busy/done handshake, starvation wait
// counter and read-data capture.
module fifo_cpu_cmd_fsm
  import fifo_buf_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stb_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [MEM_WIDTH-1:0]  wdata_i,
  input  logic                  gnt_i,
  input  logic [MEM_WIDTH-1:0]  mem_rdata_i,
  output logic                  pend_o,
  output logic                  force_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [MEM_WIDTH-1:0]  wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [MEM_WIDTH-1:0]  rdata_o
);

  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(CPU_MAX_WAIT);

  logic [1:0]            state_q, state_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
  logic [MEM_WIDTH-1:0]  rdata_q, rdata_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    unique case (state_q)
      C_IDLE: begin
        if (stb_i) begin
          state_d = C_PEND;
          wen_d   = wen_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wait_d  = '0;
        end
      end
      C_PEND: begin
        if (gnt_i) begin
          state_d = wen_q ? C_DONE : C_RDAT;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      C_RDAT: begin
        rdata_d = mem_rdata_i;
        state_d = C_DONE;
      end
      default: begin
        state_d = C_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= C_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
    end
  end

  assign pend_o  = (state_q == C_PEND);
  assign force_o = pend_o && (wait_q == WAIT_MAX);
  assign wen_o   = wen_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = (state_q == C_PEND) ||
                   (state_q == C_RDAT);
  assign done_o  = (state_q == C_DONE);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_buf_arbiter.sv
// Single-port packet buffer arbiter: ingress writes,
// egress reads and CPU commands, one access per cycle.
module fifo_buf_arbiter
  import fifo_buf_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  fifo_buf_arbiter_if.slave bus
);

  req_e             win;
  req_e             rsel_q, rsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_pend, cpu_force, cpu_wen;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [MEM_WIDTH-1:0]  cpu_wdata;
  logic [1:0]       nreq;

  fifo_cpu_cmd_fsm u_cpu (
    .clk         (clk),
    .reset_n     (reset_n),
    .stb_i       (bus.cpu_cmd_stb),
    .wen_i       (bus.cpu_wen),
    .addr_i      (bus.cpu_addr),
    .wdata_i     (bus.cpu_wdata),
    .gnt_i       (win == REQ_CPU),
    .mem_rdata_i (bus.mem_rdata),
    .pend_o      (cpu_pend),
    .force_o     (cpu_force),
    .wen_o       (cpu_wen),
    .addr_o      (cpu_addr),
    .wdata_o     (cpu_wdata),
    .busy_o      (bus.cpu_busy),
    .done_o      (bus.cpu_done),
    .rdata_o     (bus.cpu_rdata)
  );

  // Lock or exhausted wait budget lets the CPU jump the queue.
  always_comb begin
    if (cpu_force && bus.cpu_lock) win = REQ_CPU;
    else if (cpu_force) win = REQ_CPU;
    else if (!bus.cpu_lock && bus.egr_req) win = REQ_EGR;
    else if (!bus.cpu_lock && bus.ing_req) win = REQ_ING;
    else if (cpu_pend) win = REQ_CPU;
    else win = REQ_NONE;
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (win)
      REQ_ING: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.ing_addr;
        bus.mem_wdata = bus.ing_wdata;
      end
      REQ_EGR: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.egr_addr;
      end
      REQ_CPU: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = cpu_wen;
        bus.mem_addr  = cpu_addr;
        bus.mem_wdata = cpu_wen ? cpu_wdata : '0;
      end
      default: ;
    endcase
  end

  assign bus.ing_gnt = (win == REQ_ING);
  assign bus.egr_gnt = (win == REQ_EGR);

  always_comb begin
    rsel_d = REQ_NONE;
    if (win == REQ_EGR) rsel_d = REQ_EGR;
    else if (win == REQ_CPU && !cpu_wen) rsel_d = REQ_CPU;
  end

  assign bus.egr_rvalid = (rsel_q == REQ_EGR);
  assign bus.egr_rdata  = bus.egr_rvalid ?
                          bus.mem_rdata : '0;

  assign nreq = 2'(bus.ing_req) + 2'(bus.egr_req) +
                2'(cpu_pend);

  always_comb begin
    cnt_d = cnt_q;
    if (nreq >= 2'd2 && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign bus.conflict_cnt = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsel_q <= REQ_NONE;
      cnt_q  <= '0;
    end else begin
      rsel_q <= rsel_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_buf_arbiter.sv
// Directed bench for fifo_buf_arbiter with a behavioural
// single-port RAM.
module tb_fifo_buf_arbiter;
  import fifo_buf_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [MEM_WIDTH-1:0] ram [1024];
  localparam logic [MEM_WIDTH-1:0] D1 = 72'hAA_AAAA_AAAA_AAAA_AA01;
  localparam logic [MEM_WIDTH-1:0] D2 = 72'h5A_1234_5678_9ABC_DEF0;

  fifo_buf_arbiter_if bus ();

  fifo_buf_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MEM_WIDTH-1:0] pat(input int a);
    return {8'hC5, 32'h0, 32'(a)};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    bus.mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [MEM_WIDTH-1:0] obs,
                     input logic [MEM_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    bus.ing_req = 0; bus.ing_addr = '0; bus.ing_wdata = '0;
    bus.egr_req = 0; bus.egr_addr = '0;
    bus.cpu_cmd_stb = 0; bus.cpu_wen = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_lock = 0;
    #2 reset_n = 1'b0;
    nxt(); nxt(); #1;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_busy", bus.cpu_busy, 0);
    chk("rst_done", bus.cpu_done, 0);
    chk("rst_rvalid", bus.egr_rvalid, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    nxt(); reset_n = 1'b1;

    // 1: CPU write then read of 0x005
    nxt();
    bus.cpu_cmd_stb = 1; bus.cpu_wen = 1;
    bus.cpu_addr = 10'h005; bus.cpu_wdata = D1; #1;
    chk("t1_stb_busy", bus.cpu_busy, 0);
    nxt(); bus.cpu_cmd_stb = 0; #1;
    chk("t1_wr_en", bus.mem_en, 1);
    chk("t1_wr_we", bus.mem_we, 1);
    chk("t1_wr_addr", bus.mem_addr, 10'h005);
    chk("t1_wr_data", bus.mem_wdata, D1);
    chk("t1_wr_busy", bus.cpu_busy, 1);
    chk("t1_wr_nodone", bus.cpu_done, 0);
    nxt(); #1;
    chk("t1_wr_done", bus.cpu_done, 1);
    chk("t1_wr_busy0", bus.cpu_busy, 0);
    nxt();
    bus.cpu_cmd_stb = 1; bus.cpu_wen = 0;
    bus.cpu_addr = 10'h005; #1;
    chk("t1_done_pulse", bus.cpu_done, 0);
    nxt(); bus.cpu_cmd_stb = 0; #1;
    chk("t1_rd_en", bus.mem_en, 1);
    chk("t1_rd_we", bus.mem_we, 0);
    chk("t1_rd_addr", bus.mem_addr, 10'h005);
    nxt(); #1;
    chk("t1_rd_nodone", bus.cpu_done, 0);
    chk("t1_rd_rvalid", bus.egr_rvalid, 0);
    nxt(); #1;
    chk("t1_rd_done", bus.cpu_done, 1);
    chk("t1_rd_data", bus.cpu_rdata, D1);
    nxt(); #1;
    chk("t1_rd_done0", bus.cpu_done, 0);

    // 2: egress beats ingress for 4 cycles
    for (int k = 0; k < 4; k++) begin
      nxt();
      bus.ing_req = 1; bus.ing_addr = 10'h020;
      bus.ing_wdata = D2;
      bus.egr_req = 1; bus.egr_addr = 10'(16 + k); #1;
      chk("t2_egr_gnt", bus.egr_gnt, 1);
      chk("t2_ing_gnt", bus.ing_gnt, 0);
      chk("t2_addr", bus.mem_addr, 10'(16 + k));
      chk("t2_rvalid", bus.egr_rvalid, (k > 0) ? 1 : 0);
      if (k > 0) chk("t2_rdata", bus.egr_rdata, pat(15 + k));
    end
    nxt(); bus.ing_req = 0; bus.egr_req = 0; #1;
    chk("t2_last_rvalid", bus.egr_rvalid, 1);
    chk("t2_last_rdata", bus.egr_rdata, pat(19));
    chk("t2_cnt", bus.conflict_cnt, 4);
    chk("t2_idle_en", bus.mem_en, 0);

    // 3: CPU read starved by egress
    nxt();
    bus.cpu_cmd_stb = 1; bus.cpu_wen = 0;
    bus.cpu_addr = 10'h007;
    bus.egr_req = 1; bus.egr_addr = 10'h030; #1;
    chk("t3_stb_egr", bus.egr_gnt, 1);
    for (int p = 1; p <= 9; p++) begin
      nxt(); bus.cpu_cmd_stb = 0; #1;
      chk("t3_busy", bus.cpu_busy, 1);
      chk("t3_egr_gnt", bus.egr_gnt, (p < 9) ? 1 : 0);
      if (p == 9) chk("t3_cpu_addr", bus.mem_addr, 10'h007);
    end
    nxt(); #1;
    chk("t3_regrant", bus.egr_gnt, 1);
    chk("t3_no_rvalid", bus.egr_rvalid, 0);
    chk("t3_cnt", bus.conflict_cnt, 13);
    nxt(); bus.egr_req = 0; #1;
    chk("t3_done", bus.cpu_done, 1);
    chk("t3_rdata", bus.cpu_rdata, pat(7));
    chk("t3_egr_rdata", bus.egr_rdata, pat(48));

    // 4: lock blocks packet traffic
    nxt();
    bus.cpu_lock = 1; bus.ing_req = 1; bus.egr_req = 1;
    bus.egr_addr = 10'h050;
    bus.cpu_cmd_stb = 1; bus.cpu_wen = 1;
    bus.cpu_addr = 10'h040; bus.cpu_wdata = D2; #1;
    chk("t4_ing_gnt", bus.ing_gnt, 0);
    chk("t4_egr_gnt", bus.egr_gnt, 0);
    chk("t4_idle_en", bus.mem_en, 0);
    nxt(); bus.cpu_cmd_stb = 0; #1;
    chk("t4_cpu_we", bus.mem_we, 1);
    chk("t4_cpu_addr", bus.mem_addr, 10'h040);
    chk("t4_egr_gnt2", bus.egr_gnt, 0);
    nxt(); #1;
    chk("t4_done", bus.cpu_done, 1);
    chk("t4_ing_gnt2", bus.ing_gnt, 0);
    nxt(); bus.cpu_lock = 0; #1;
    chk("t4_unlock_egr", bus.egr_gnt, 1);
    chk("t4_unlock_addr", bus.mem_addr, 10'h050);
    chk("t4_cnt", bus.conflict_cnt, 16);
    nxt(); bus.ing_req = 0; bus.egr_req = 0;

    // 5: strobe while busy, then reset during C_RDAT
    nxt();
    bus.cpu_cmd_stb = 1; bus.cpu_wen = 0;
    bus.cpu_addr = 10'h040; #1;
    nxt();
    bus.cpu_wen = 1; bus.cpu_addr = 10'h099; #1;
    chk("t5_first_addr", bus.mem_addr, 10'h040);
    chk("t5_first_we", bus.mem_we, 0);
    nxt(); bus.cpu_cmd_stb = 0; #1;
    chk("t5_rdat_busy", bus.cpu_busy, 1);
    chk("t5_rdat_en", bus.mem_en, 0);
    reset_n = 1'b0; #1;
    chk("t5_rst_busy", bus.cpu_busy, 0);
    chk("t5_rst_done", bus.cpu_done, 0);
    chk("t5_rst_rdata", bus.cpu_rdata, 0);
    chk("t5_rst_cnt", bus.conflict_cnt, 0);
    chk("t5_rst_rvalid", bus.egr_rvalid, 0);
    nxt(); #1;
    chk("t5_rst_done2", bus.cpu_done, 0);
    reset_n = 1'b1;
    nxt(); #1;
    chk("t5_post_done", bus.cpu_done, 0);
    chk("t5_post_busy", bus.cpu_busy, 0);
    chk("t5_post_en", bus.mem_en, 0);
    nxt(); #1;
    chk("t5_post_done2", bus.cpu_done, 0);
    chk("t5_post_rdata", bus.cpu_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
